core_step_ctrl: RTL and testbench
=================================

Name: core_step_ctrl

Overview:
- Multi-cycle sequencer for the RV32E-style core datapath (PC, IFU, IDU, register file, EXU, LSU).
- One instruction in flight: fetch over a valid/ready instruction-memory handshake, decode, execute, optional data-memory access, write-back.
- Asserts the per-stage enables: instruction latch, register-file write, PC update.
- Detects ebreak (halt), illegal instructions and memory timeouts; counts retired instructions.
- Sits between the top-level datapath and the memory interfaces.

Parameters:
- TIMEOUT, 255, max cycles spent in any memory REQ/WAIT state before the error is raised; 0 disables the check.
- TMR_W, 8, width of the wait-timer counter; must satisfy 2^TMR_W > TIMEOUT.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- if_req_valid  out  1  instruction fetch request (address = current PC)
- if_req_ready  in  1  imem accepts request
- if_rsp_valid  in  1  imem returns instruction this cycle
- inst_we  out  1  latch instruction into IFU register
- dec_is_load  in  1  decoded load (valid in EXEC)
- dec_is_store  in  1  decoded store (valid in EXEC)
- dec_is_ebreak  in  1  decoded ebreak (valid in EXEC)
- dec_illegal  in  1  unrecognised opcode (valid in EXEC)
- dec_rd_wen  in  1  instruction writes rd
- mem_req_valid  out  1  data memory request
- mem_req_wr  out  1  1 = store, 0 = load; stable while mem_req_valid
- mem_req_ready  in  1  dmem accepts request
- mem_rsp_valid  in  1  dmem load data / store ack
- rf_wen  out  1  register-file write enable
- pc_wen  out  1  PC update enable (next PC selected by EXU)
- retire  out  1  one-cycle pulse per retired instruction
- instret  out  INSTRET_W  retired-instruction count
- halted  out  1  sticky, ebreak reached
- err  out  1  sticky, error state
- err_code  out  2  0 none, 1 illegal, 2 fetch timeout, 3 mem timeout

Behaviour:
- Clock and reset: clk, single clock; rst is synchronous, active-high. Reset wins over every other event, including mid-handshake.
- State on reset: FETCH_REQ.
- Outputs on reset: all 0; instret = 0, halted = 0, err = 0, err_code = 0, timer = 0. The first FETCH_REQ cycle after reset asserts if_req_valid.
- States (4-bit encoding): FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERROR.
- FETCH_REQ: if_req_valid = 1. On if_req_ready go to FETCH_WAIT.
- FETCH_WAIT: on if_rsp_valid, inst_we = 1 (combinational in this state), go to DECODE.
- DECODE: exactly 1 cycle, register-file read settles; go to EXEC.
- EXEC: 1 cycle; priority order:
  - dec_illegal -> ERROR, err_code = 1
  - dec_is_ebreak -> HALT
  - dec_is_load or dec_is_store -> MEM_REQ
  - otherwise -> WB
- MEM_REQ: mem_req_valid = 1, mem_req_wr = dec_is_store. Hold both until mem_req_ready, then go to MEM_WAIT.
- MEM_WAIT: on mem_rsp_valid go to WB.
- WB: 1 cycle.
  - rf_wen = dec_rd_wen & ~dec_is_store.
  - pc_wen = 1; retire = 1; instret increments (wraps modulo 2^INSTRET_W).
  - Go to FETCH_REQ.
- HALT: halted = 1; all enables 0; terminal until rst. ebreak does not pulse retire and does not increment instret.
- ERROR: err = 1; err_code held; all enables 0; terminal until rst.
- Timer:
  - Clears to 0 on every state change.
  - Increments each cycle spent in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT without the exiting handshake.
  - When TIMEOUT != 0 and timer == TIMEOUT-1 with no handshake: go to ERROR. err_code = 2 for fetch states, 3 for memory states.
  - A handshake arriving in the same cycle as expiry wins; no error is raised.
- Responses: spurious if_rsp_valid or mem_rsp_valid outside the matching WAIT state is ignored.
- Handshake fire: ready in the same cycle as valid counts as a fire.
- Minimum latency (zero-wait memory):
  - non-memory instruction: 5 cycles
  - load/store: 7 cycles

Decomposition:
- Shared package core_ctrl_pkg holds:
  - state enum and its 4-bit encoding
  - err_code constants: ERR_NONE, ERR_ILLEGAL, ERR_IF_TO, ERR_MEM_TO
- Sub-module core_wait_timer (clear, enable, expired output, TIMEOUT/TMR_W parameters) keeps the FSM free of counter logic.

Test Plan:
- addi with if_req_ready and if_rsp_valid tied high, after rst -> inst_we at cycle 2; rf_wen, pc_wen, retire at cycle 5; instret = 1.
- lw with mem_req_ready delayed 3 cycles and mem_rsp_valid 2 cycles later -> mem_req_valid held 4 cycles with mem_req_wr = 0; rf_wen in WB; total 12 cycles.
- sw with dec_rd_wen = 1 -> mem_req_wr = 1; rf_wen stays 0; pc_wen = 1; instret += 1.
- dec_is_ebreak in EXEC -> halted = 1 next cycle and sticky; no further if_req_valid; instret unchanged; rst clears halted.
- TIMEOUT = 4, if_rsp_valid never asserted -> err = 1, err_code = 2 after the 4th FETCH_WAIT cycle. Repeat with rsp_valid on that 4th cycle -> no error, DECODE entered.
- dec_illegal and dec_is_ebreak both high -> ERROR, err_code = 1, halted = 0. rst asserted in MEM_WAIT -> next cycle FETCH_REQ with all outputs cleared.

Source files
------------

// File: rtl/core_step_ctrl_pkg.sv
// core_ctrl_pkg: shared state encoding and error codes for the step controller
package core_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH_REQ  = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC       = 4'd3,
    S_MEM_REQ    = 4'd4,
    S_MEM_WAIT   = 4'd5,
    S_WB         = 4'd6,
    S_HALT       = 4'd7,
    S_ERROR      = 4'd8
  } state_t;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_IF_TO   = 2'd2;
  localparam logic [1:0] ERR_MEM_TO  = 2'd3;
endpackage

// File: rtl/core_step_ctrl_if.sv
// core_step_ctrl_if: instruction/data memory handshakes between controller and memories
interface core_step_ctrl_if;
  logic if_req_valid;
  logic if_req_ready;
  logic if_rsp_valid;
  logic inst_we;
  logic mem_req_valid;
  logic mem_req_wr;
  logic mem_req_ready;
  logic mem_rsp_valid;
  modport master (
    output if_req_valid, inst_we, mem_req_valid, mem_req_wr,
    input  if_req_ready, if_rsp_valid, mem_req_ready, mem_rsp_valid
  );
  modport slave (
    input  if_req_valid, inst_we, mem_req_valid, mem_req_wr,
    output if_req_ready, if_rsp_valid, mem_req_ready, mem_rsp_valid
  );
endinterface

// File: rtl/core_step_ctrl_wait_timer.sv
// core_wait_timer: cycle counter for memory wait states, flags the last allowed cycle
module core_wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int TMR_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [TMR_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  // caller qualifies with "still waiting", so a same-cycle handshake wins
  assign expired = (TIMEOUT != 0) && (cnt == TMR_W'(TIMEOUT - 1));
endmodule

// File: rtl/core_step_ctrl.sv
// core_step_ctrl: multi-cycle fetch/decode/exec/mem/wb sequencer with halt, error and retire tracking
module core_step_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int TMR_W     = 8,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  core_step_ctrl_if.master     bus,
  input  logic                 dec_is_load,
  input  logic                 dec_is_store,
  input  logic                 dec_is_ebreak,
  input  logic                 dec_illegal,
  input  logic                 dec_rd_wen,
  output logic                 rf_wen,
  output logic                 pc_wen,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted,
  output logic                 err,
  output logic [1:0]           err_code
);
  state_t state, state_n;
  logic fire, in_wait, wait_en, expired, st_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH_REQ;
      err_code <= ERR_NONE;
      instret  <= '0;
      st_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_EXEC) st_q <= dec_is_store;
      if (state == S_WB) instret <= instret + 1'b1;
      if (state == S_EXEC && dec_illegal) err_code <= ERR_ILLEGAL;
      else if (wait_en && expired)
        err_code <= (state == S_MEM_REQ || state == S_MEM_WAIT) ? ERR_MEM_TO : ERR_IF_TO;
    end
  end
  always_comb begin
    fire    = 1'b0;
    state_n = state;
    case (state)
      S_FETCH_REQ: begin
        fire    = bus.if_req_ready;
        state_n = fire ? S_FETCH_WAIT : state;
      end
      S_FETCH_WAIT: begin
        fire    = bus.if_rsp_valid;
        state_n = fire ? S_DECODE : state;
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: state_n = dec_illegal ? S_ERROR : dec_is_ebreak ? S_HALT :
                        (dec_is_load || dec_is_store) ? S_MEM_REQ : S_WB;
      S_MEM_REQ: begin
        fire    = bus.mem_req_ready;
        state_n = fire ? S_MEM_WAIT : state;
      end
      S_MEM_WAIT: begin
        fire    = bus.mem_rsp_valid;
        state_n = fire ? S_WB : state;
      end
      S_WB: state_n = S_FETCH_REQ;
      default: state_n = state;
    endcase
    in_wait = state inside {S_FETCH_REQ, S_FETCH_WAIT, S_MEM_REQ, S_MEM_WAIT};
    wait_en = in_wait && !fire;
    if (wait_en && expired) state_n = S_ERROR;
  end
  core_wait_timer #(.TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_n != state),
    .en      (wait_en),
    .expired (expired)
  );
  assign bus.if_req_valid  = state == S_FETCH_REQ;
  assign bus.inst_we       = state == S_FETCH_WAIT && bus.if_rsp_valid;
  assign bus.mem_req_valid = state == S_MEM_REQ;
  assign bus.mem_req_wr    = state == S_MEM_REQ && st_q;
  assign rf_wen            = state == S_WB && dec_rd_wen && !dec_is_store;
  assign pc_wen            = state == S_WB;
  assign retire            = state == S_WB;
  assign halted            = state == S_HALT;
  assign err               = state == S_ERROR;
endmodule

// File: tb/tb_core_step_ctrl.sv
// tb_core_step_ctrl: scoreboard bench for the step controller (TIMEOUT=4)
module tb_core_step_ctrl;
  import core_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal, dec_rd_wen;
  logic rf_wen, pc_wen, retire, halted, err;
  logic [31:0] instret;
  logic [1:0] err_code;
  int n_chk = 0;
  int n_fail = 0;
  int exp_instret = 0;
  int cyc;
  typedef struct {logic rf; logic [31:0] cnt;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  core_step_ctrl_if bus();
  core_step_ctrl #(.TIMEOUT(4), .TMR_W(3), .INSTRET_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.master),
    .dec_is_load   (dec_is_load),
    .dec_is_store  (dec_is_store),
    .dec_is_ebreak (dec_is_ebreak),
    .dec_illegal   (dec_illegal),
    .dec_rd_wen    (dec_rd_wen),
    .rf_wen        (rf_wen),
    .pc_wen        (pc_wen),
    .retire        (retire),
    .instret       (instret),
    .halted        (halted),
    .err           (err),
    .err_code      (err_code)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in;
    bus.if_req_ready = 0; bus.if_rsp_valid = 0; bus.mem_req_ready = 0; bus.mem_rsp_valid = 0;
    dec_is_load = 0; dec_is_store = 0; dec_is_ebreak = 0; dec_illegal = 0; dec_rd_wen = 0;
  endtask
  task automatic do_reset;
    rst = 1;
    tick;
    tick;
    rst = 0;
    exp_instret = 0;
  endtask
  // drives one instruction; ends one cycle after EXEC (halt/error) or after WB
  task automatic run_inst(input logic ld, st, eb, ill, rdw, input int ifr, ifs, mr, ms, output int n);
    n = 0;
    dec_is_load = ld; dec_is_store = st; dec_is_ebreak = eb; dec_illegal = ill; dec_rd_wen = rdw;
    if (!eb && !ill) sb.push_back('{rf: rdw & ~st, cnt: exp_instret});
    for (int k = 0; k <= ifr; k++) begin
      bus.if_req_ready = (k == ifr);
      #1 check("if_req_valid", bus.if_req_valid, 1);
      tick; n++;
    end
    bus.if_req_ready = 0;
    for (int k = 0; k <= ifs; k++) begin
      bus.if_rsp_valid = (k == ifs);
      #1 check("inst_we", bus.inst_we, k == ifs);
      tick; n++;
    end
    bus.if_rsp_valid = 0;
    tick; n++;
    tick; n++;
    if (eb || ill) return;
    if (ld || st) begin
      for (int k = 0; k <= mr; k++) begin
        bus.mem_req_ready = (k == mr);
        #1 check("mem_req_valid", bus.mem_req_valid, 1);
        check("mem_req_wr", bus.mem_req_wr, st);
        tick; n++;
      end
      bus.mem_req_ready = 0;
      for (int k = 0; k <= ms; k++) begin
        bus.mem_rsp_valid = (k == ms);
        #1 check("mem_wait_no_req", bus.mem_req_valid, 0);
        tick; n++;
      end
      bus.mem_rsp_valid = 0;
    end
    tick; n++;
    exp_instret++;
  endtask
  initial begin
    exp_t e;
    forever begin
      tick;
      if (retire === 1'b1) begin
        if (sb.size() == 0) check("retire_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("wb_rf_wen", rf_wen, e.rf);
          check("wb_pc_wen", pc_wen, 1);
          check("wb_instret_before", instret, e.cnt);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    clear_in;
    do_reset;
    check("rst_if_req_valid", bus.if_req_valid, 1);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_retire", retire, 0);
    check("rst_instret", instret, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, ERR_NONE);
    run_inst(0, 0, 0, 0, 1, 0, 0, 0, 0, cyc);
    check("addi_cycles", cyc, 5);
    check("addi_instret", instret, 1);
    run_inst(1, 0, 0, 0, 1, 0, 0, 3, 2, cyc);
    check("lw_cycles", cyc, 12);
    check("lw_instret", instret, 2);
    run_inst(0, 1, 0, 0, 1, 0, 0, 0, 0, cyc);
    check("sw_cycles", cyc, 7);
    check("sw_instret", instret, 3);
    run_inst(0, 0, 0, 0, 0, 0, 3, 0, 0, cyc);
    check("late_rsp_cycles", cyc, 8);
    check("late_rsp_err", err, 0);
    run_inst(0, 0, 1, 0, 0, 0, 0, 0, 0, cyc);
    for (int k = 0; k < 4; k++) begin
      check("halt_halted", halted, 1);
      check("halt_no_fetch", bus.if_req_valid, 0);
      check("halt_pc_wen", pc_wen, 0);
      check("halt_instret", instret, 4);
      tick;
    end
    clear_in;
    do_reset;
    check("halt_rst_halted", halted, 0);
    check("halt_rst_fetch", bus.if_req_valid, 1);
    bus.if_req_ready = 1;
    tick;
    bus.if_req_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("if_to_not_yet", err, 0);
    end
    tick;
    check("if_to_err", err, 1);
    check("if_to_code", err_code, ERR_IF_TO);
    bus.if_rsp_valid = 1;
    tick;
    check("if_to_sticky", err, 1);
    check("if_to_no_inst_we", bus.inst_we, 0);
    clear_in;
    do_reset;
    check("err_rst", err, 0);
    run_inst(0, 0, 1, 1, 0, 0, 0, 0, 0, cyc);
    check("ill_err", err, 1);
    check("ill_code", err_code, ERR_ILLEGAL);
    check("ill_not_halted", halted, 0);
    clear_in;
    do_reset;
    dec_is_load = 1;
    bus.if_req_ready = 1;
    tick;
    bus.if_req_ready = 0;
    bus.if_rsp_valid = 1;
    tick;
    bus.if_rsp_valid = 0;
    tick;
    tick;
    for (int k = 0; k < 4; k++) begin
      check("mem_to_req", bus.mem_req_valid, 1);
      tick;
    end
    check("mem_to_err", err, 1);
    check("mem_to_code", err_code, ERR_MEM_TO);
    clear_in;
    do_reset;
    dec_is_load = 1;
    dec_rd_wen = 1;
    bus.if_req_ready = 1;
    tick;
    bus.if_req_ready = 0;
    bus.if_rsp_valid = 1;
    tick;
    bus.if_rsp_valid = 0;
    tick;
    tick;
    bus.mem_req_ready = 1;
    tick;
    bus.mem_req_ready = 0;
    check("mw_no_req", bus.mem_req_valid, 0);
    rst = 1;
    bus.mem_rsp_valid = 1;
    tick;
    rst = 0;
    clear_in;
    check("mw_rst_fetch", bus.if_req_valid, 1);
    check("mw_rst_mem_req", bus.mem_req_valid, 0);
    check("mw_rst_rf_wen", rf_wen, 0);
    check("mw_rst_retire", retire, 0);
    check("mw_rst_instret", instret, 0);
    check("mw_rst_err", err, 0);
    run_inst(0, 0, 0, 0, 1, 1, 1, 0, 0, cyc);
    check("resume_cycles", cyc, 7);
    check("resume_instret", instret, 1);
    tick;
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
